// File: rtl/exc_seq.sv
// Exception/ERET request sequencer for the CP0 trap interface.
// Issues a one-cycle CP0 request, then a one-cycle PC redirect, stalling the pipeline throughout.
module exc_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic             is_syscall,
  input  logic             is_break,
  input  logic             is_teq,
  input  logic             teq_eq,
  input  logic             is_eret,
  input  logic [31:0]      pc_next,
  input  logic [31:0]      cp0_status,
  output logic             cp0_ena,
  output logic             cp0_exception,
  output logic             cp0_eret,
  output logic [4:0]       cp0_cause,
  output logic [31:0]      cp0_npc,
  output logic             stall,
  output logic             pc_sel_exc,
  output logic             busy,
  output logic [CNT_W-1:0] exc_count
);

  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

  // Three bits leave room for undefined encodings, which fall back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXC_REQ  = 3'd1,
    ST_ERET_REQ = 3'd2,
    ST_REDIR    = 3'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [4:0]       cause_reg, cause_next;
  logic [31:0]      npc_reg, npc_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [2:0] cand;
  logic [2:0] sel;
  logic [2:0] class_en;
  logic [2:0] take;
  logic [4:0] take_cause;
  logic       eret_only;
  logic       status_unused;

  // Candidate classes in priority order: bit0 SYSCALL, bit1 BREAK, bit2 TEQ.
  assign cand = {is_teq & teq_eq, is_break, is_syscall};

  always_comb begin
    sel = 3'b000;
    if (cand[0])      sel = 3'b001;
    else if (cand[1]) sel = 3'b010;
    else if (cand[2]) sel = 3'b100;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_class
      assign class_en[gi] = cp0_status[0] & cp0_status[gi+1];
      assign take[gi]     = sel[gi] & class_en[gi];
    end
  endgenerate

  always_comb begin
    take_cause = 5'b00000;
    case (take)
      3'b001:  take_cause = CAUSE_SYSCALL;
      3'b010:  take_cause = CAUSE_BREAK;
      3'b100:  take_cause = CAUSE_TEQ;
      default: take_cause = 5'b00000;
    endcase
  end

  // A masked exception candidate suppresses a simultaneous ERET rather than falling through.
  assign eret_only     = is_eret & ~(|cand);
  assign status_unused = ^cp0_status[31:4];

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    npc_next   = npc_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (inst_valid) begin
          if (|take) begin
            state_next = ST_EXC_REQ;
            cause_next = take_cause;
            npc_next   = pc_next;
            if (count_reg != {CNT_W{1'b1}})
              count_next = count_reg + CNT_W'(1);
          end else if (eret_only) begin
            state_next = ST_ERET_REQ;
          end
        end
      end
      ST_EXC_REQ:  state_next = ST_REDIR;
      ST_ERET_REQ: state_next = ST_REDIR;
      ST_REDIR:    state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cause_reg <= 5'b00000;
      npc_reg   <= 32'h0000_0000;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      npc_reg   <= npc_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    cp0_ena       = 1'b0;
    cp0_exception = 1'b0;
    cp0_eret      = 1'b0;
    stall         = 1'b0;
    pc_sel_exc    = 1'b0;
    busy          = 1'b0;
    case (state_reg)
      ST_EXC_REQ: begin
        cp0_ena       = 1'b1;
        cp0_exception = 1'b1;
        stall         = 1'b1;
        busy          = 1'b1;
      end
      ST_ERET_REQ: begin
        cp0_ena  = 1'b1;
        cp0_eret = 1'b1;
        stall    = 1'b1;
        busy     = 1'b1;
      end
      ST_REDIR: begin
        pc_sel_exc = 1'b1;
        stall      = 1'b1;
        busy       = 1'b1;
      end
      default: begin
        cp0_ena = 1'b0;
      end
    endcase
  end

  assign cp0_cause = cause_reg;
  assign cp0_npc   = npc_reg;
  assign exc_count = count_reg;

endmodule

// File: tb/tb_exc_seq.sv
// Scoreboard bench for exc_seq: a default-width and a 2-bit-counter instance share stimulus.
module tb_exc_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, inst_valid, is_syscall, is_break, is_teq, teq_eq, is_eret;
  logic [31:0] pc_next, cp0_status;

  logic        a_ena, a_exc, a_eret, a_stall, a_pcsel, a_busy;
  logic [4:0]  a_cause;
  logic [31:0] a_npc;
  logic [15:0] a_cnt;
  logic        b_ena, b_exc, b_eret, b_stall, b_pcsel, b_busy;
  logic [4:0]  b_cause;
  logic [31:0] b_npc;
  logic [1:0]  b_cnt;

  exc_seq dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .is_syscall(is_syscall),
    .is_break(is_break), .is_teq(is_teq), .teq_eq(teq_eq), .is_eret(is_eret),
    .pc_next(pc_next), .cp0_status(cp0_status), .cp0_ena(a_ena),
    .cp0_exception(a_exc), .cp0_eret(a_eret), .cp0_cause(a_cause), .cp0_npc(a_npc),
    .stall(a_stall), .pc_sel_exc(a_pcsel), .busy(a_busy), .exc_count(a_cnt)
  );

  exc_seq #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .is_syscall(is_syscall),
    .is_break(is_break), .is_teq(is_teq), .teq_eq(teq_eq), .is_eret(is_eret),
    .pc_next(pc_next), .cp0_status(cp0_status), .cp0_ena(b_ena),
    .cp0_exception(b_exc), .cp0_eret(b_eret), .cp0_cause(b_cause), .cp0_npc(b_npc),
    .stall(b_stall), .pc_sel_exc(b_pcsel), .busy(b_busy), .exc_count(b_cnt)
  );

  typedef struct packed {
    logic [5:0]  ctl;
    logic [4:0]  cause;
    logic [31:0] npc;
    logic [15:0] cnt;
    logic [1:0]  cnt_sat;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_txn = 0;

  // Reference model: 0 idle, 1 exception request, 2 eret request, 3 redirect.
  int          m_state = 0;
  logic [4:0]  m_cause = 5'd0;
  logic [31:0] m_npc = 32'd0;
  logic [15:0] m_cnt = 16'd0;
  logic [1:0]  m_cnt_sat = 2'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (txn %0d)", tag, act, exp, n_txn);
    end
  endtask

  task automatic model(input logic r, v, s, b, t, e, er, input logic [31:0] pc, st);
    int cls;
    logic [4:0] cc;
    cls = 0;
    cc = 5'd0;
    if (!r) begin
      m_state = 0; m_cause = 5'd0; m_npc = 32'd0; m_cnt = 16'd0; m_cnt_sat = 2'd0;
    end else begin
      case (m_state)
        0: if (v) begin
          if (s)           begin cls = 1; cc = 5'b01000; end
          else if (b)      begin cls = 2; cc = 5'b01001; end
          else if (t && e) begin cls = 3; cc = 5'b01101; end
          if (cls != 0) begin
            if (st[0] && st[cls]) begin
              m_state = 1; m_cause = cc; m_npc = pc;
              if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
              if (m_cnt_sat != 2'b11) m_cnt_sat = m_cnt_sat + 2'd1;
            end
          end else if (er) begin
            m_state = 2;
          end
        end
        1, 2:    m_state = 3;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic step(input logic r, v, s, b, t, e, er, input logic [31:0] pc, st);
    exp_t x, got;
    @(negedge clk);
    rst = r; inst_valid = v; is_syscall = s; is_break = b; is_teq = t;
    teq_eq = e; is_eret = er; pc_next = pc; cp0_status = st;
    model(r, v, s, b, t, e, er, pc, st);
    x.ctl = {(m_state == 1 || m_state == 2), m_state == 1, m_state == 2,
             m_state != 0, m_state == 3, m_state != 0};
    x.cause = m_cause; x.npc = m_npc; x.cnt = m_cnt; x.cnt_sat = m_cnt_sat;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    n_txn++;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check("ctl",       {26'd0, a_ena, a_exc, a_eret, a_stall, a_pcsel, a_busy}, {26'd0, got.ctl});
      check("cause",     {27'd0, a_cause}, {27'd0, got.cause});
      check("npc",       a_npc, got.npc);
      check("count",     {16'd0, a_cnt}, {16'd0, got.cnt});
      check("ctl_sat",   {26'd0, b_ena, b_exc, b_eret, b_stall, b_pcsel, b_busy}, {26'd0, got.ctl});
      check("count_sat", {30'd0, b_cnt}, {30'd0, got.cnt_sat});
      $display("txn %0d rst=%b v=%b s/b/t/e/er=%b%b%b%b%b st=%h -> ctl=%b cause=%h npc=%h cnt=%0d sat=%0d",
               n_txn, r, v, s, b, t, e, er, st[3:0], got.ctl, got.cause, got.npc, got.cnt, got.cnt_sat);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; inst_valid = 1'b0; is_syscall = 1'b0; is_break = 1'b0; is_teq = 1'b0;
    teq_eq = 1'b0; is_eret = 1'b0; pc_next = 32'h0; cp0_status = 32'h0;

    // Reset held with a pending syscall
    step(0, 1, 1, 0, 0, 0, 0, 32'h00400120, 32'hF);
    step(0, 1, 1, 0, 0, 0, 0, 32'h00400120, 32'hF);
    idle(2);

    // Taken SYSCALL
    step(1, 1, 1, 0, 0, 0, 0, 32'h00400120, 32'h0000000F);
    idle(4);

    // Decode inputs held while busy are ignored
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0, 0, 32'h00400200, 32'hF);
    idle(1);

    // Masking
    step(1, 1, 0, 1, 0, 0, 0, 32'h00400300, 32'h0000000B); idle(1);
    step(1, 1, 1, 0, 0, 0, 0, 32'h00400304, 32'h0000000E); idle(1);
    step(1, 1, 0, 0, 1, 0, 0, 32'h00400308, 32'h0000000F); idle(1);
    step(1, 1, 0, 1, 1, 1, 1, 32'h0040030C, 32'h0000000B); idle(1);

    // Priority and TEQ
    step(1, 1, 0, 1, 1, 1, 0, 32'h00400310, 32'hF); idle(3);
    step(1, 1, 0, 0, 1, 1, 0, 32'h00400400, 32'hF); idle(3);

    // ERET with Status cleared
    step(1, 1, 0, 0, 0, 0, 1, 32'h00400500, 32'h0); idle(3);

    // Reset during the request cycle
    step(1, 1, 1, 0, 0, 0, 0, 32'h00400600, 32'hF);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'hF);
    idle(3);

    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 0, 0, 0, 0, 32'h00401000 + 32'(i * 4), 32'hF);
      idle(2);
    end

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom, {28'd0, 4'($urandom)});
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
